// File: rtl/bn_apply_unit.sv
// Batch-norm apply stage: y = ((x - mean) * inv_std) * gamma + beta, saturated, optional ReLU.
// Channel parameters are captured alongside each sample so that a channel advance never disturbs in-flight data.
module bn_apply_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 8,
  parameter int OUT_CHANNELS  = 64,
  parameter int PIXELS_PER_CH = 16,
  parameter int RELU_EN       = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic signed [DATA_WIDTH-1:0]    in_data,
  output logic                            in_ready,
  input  logic signed [DATA_WIDTH-1:0]    mean_in,
  input  logic signed [DATA_WIDTH-1:0]    inv_std_in,
  input  logic signed [DATA_WIDTH-1:0]    gamma_in,
  input  logic signed [DATA_WIDTH-1:0]    beta_in,
  output logic                            param_en,
  output logic                            out_valid,
  output logic signed [DATA_WIDTH-1:0]    out_data,
  input  logic                            out_ready,
  output logic [$clog2(OUT_CHANNELS)-1:0] channel_idx,
  output logic                            frame_done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(OUT_CHANNELS);
  localparam int PW = (PIXELS_PER_CH > 1) ? $clog2(PIXELS_PER_CH) : 1;

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] ADV   = 3'd2;
  localparam logic [2:0] WAIT1 = 3'd3;
  localparam logic [2:0] WAIT2 = 3'd4;

  localparam logic [DW-1:0] SMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS_PER_CH - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(OUT_CHANNELS - 1);

  logic [2:0]    state_q, state_d;
  logic          init_q, init_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [CW-1:0] chan_q, chan_d;

  logic                 pipe_en, accept;
  logic                 s1_v_q, s2_v_q, out_valid_q;
  logic signed [DW:0]   s1_diff_q, diff_d;
  logic [DW-1:0]        s1_inv_q, s1_gam_q, s1_beta_q;
  logic [DW-1:0]        s2_p_q, s2_gam_q, s2_beta_q, p_d;
  logic [DW-1:0]        out_data_q, q_d;
  logic signed [2*DW:0]   prod1, sh1, sum;
  logic signed [2*DW-1:0] prod2, sh2;

  assign pipe_en     = !out_valid_q || out_ready;
  assign in_ready    = (state_q == RUN) && pipe_en;
  assign accept      = in_valid && in_ready;
  assign param_en    = (state_q == ADV);
  assign frame_done  = (state_q == ADV) && (chan_q == CH_LAST);
  assign channel_idx = chan_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

  // Sequencing deliberately ignores backpressure: parameters already travel with each sample.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    pix_d   = pix_q;
    chan_d  = chan_q;
    case (state_q)
      INIT: begin
        if (init_q) state_d = RUN;
        else        init_d  = 1'b1;
      end
      RUN: begin
        if (accept) begin
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            state_d = ADV;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      ADV: begin
        state_d = WAIT1;
        chan_d  = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
      end
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      init_q  <= 1'b0;
      pix_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      pix_q   <= pix_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    diff_d = {in_data[DW-1], in_data} - {mean_in[DW-1], mean_in};

    prod1 = $signed({{DW{s1_diff_q[DW]}}, s1_diff_q}) *
            $signed({{(DW+1){s1_inv_q[DW-1]}}, s1_inv_q});
    sh1   = prod1 >>> FRAC_BITS;
    if (sh1[2*DW:DW-1] == '0 || sh1[2*DW:DW-1] == '1) p_d = sh1[DW-1:0];
    else                                               p_d = sh1[2*DW] ? SMIN : SMAX;

    prod2 = $signed({{DW{s2_p_q[DW-1]}}, s2_p_q}) *
            $signed({{DW{s2_gam_q[DW-1]}}, s2_gam_q});
    sh2   = prod2 >>> FRAC_BITS;
    sum   = {sh2[2*DW-1], sh2} + {{(DW+1){s2_beta_q[DW-1]}}, s2_beta_q};
    if (sum[2*DW:DW-1] == '0 || sum[2*DW:DW-1] == '1) q_d = sum[DW-1:0];
    else                                               q_d = sum[2*DW] ? SMIN : SMAX;
    if (RELU_EN != 0 && q_d[DW-1]) q_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_diff_q   <= '0;
      s1_inv_q    <= '0;
      s1_gam_q    <= '0;
      s1_beta_q   <= '0;
      s2_v_q      <= 1'b0;
      s2_p_q      <= '0;
      s2_gam_q    <= '0;
      s2_beta_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pipe_en) begin
      s1_v_q <= accept;
      if (accept) begin
        s1_diff_q <= diff_d;
        s1_inv_q  <= inv_std_in;
        s1_gam_q  <= gamma_in;
        s1_beta_q <= beta_in;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_p_q    <= p_d;
        s2_gam_q  <= s1_gam_q;
        s2_beta_q <= s1_beta_q;
      end
      out_valid_q <= s2_v_q;
      if (s2_v_q) out_data_q <= q_d;
    end
  end

endmodule

// File: tb/tb_bn_apply_unit.sv
// Bench for bn_apply_unit: directed vectors, control timeline, stall, random traffic and mid-flight reset,
// with a scoreboard fed by an integer reference model of the normalisation.
module tb_bn_apply_unit;

  localparam int NCH = 2;
  localparam int NPIX = 4;

  logic        clk, rst_n, in_valid, in_ready, param_en, out_valid, out_ready, frame_done;
  logic [15:0] in_data, out_data, mean_in, inv_std_in, gamma_in, beta_in;
  logic [0:0]  channel_idx;

  logic [15:0] mean_t[NCH], inv_t[NCH], gam_t[NCH], beta_t[NCH];

  int errors = 0;
  int checks = 0;

  bn_apply_unit #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .OUT_CHANNELS(NCH), .PIXELS_PER_CH(NPIX), .RELU_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mean_in(mean_in), .inv_std_in(inv_std_in), .gamma_in(gamma_in), .beta_in(beta_in),
    .param_en(param_en), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .channel_idx(channel_idx), .frame_done(frame_done)
  );

  assign mean_in    = mean_t[channel_idx];
  assign inv_std_in = inv_t[channel_idx];
  assign gamma_in   = gam_t[channel_idx];
  assign beta_in    = beta_t[channel_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Fixed-point arithmetic on plain integers; >>> on a signed longint is floor division by 2^8.
  function automatic logic [15:0] bn_ref(input logic [15:0] x, m, inv, g, b);
    longint d, p, q;
    d = longint'($signed(x)) - longint'($signed(m));
    p = clamp16((d * longint'($signed(inv))) >>> 8);
    q = clamp16(((p * longint'($signed(g))) >>> 8) + longint'($signed(b)));
    if (q < 0) q = 0;
    return 16'(q);
  endfunction

  logic [15:0] expq[$];
  int acc_m = 0;

  always @(negedge clk) begin
    int ch;
    if (!rst_n) begin
      expq.delete();
      acc_m = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
        else                  chk("sb_out_data", 32'(out_data), 32'(expq.pop_front()));
      end
      if (in_valid && in_ready) begin
        ch = (acc_m / NPIX) % NCH;
        chk("chan_at_accept", 32'(channel_idx), 32'(ch));
        expq.push_back(bn_ref(in_data, mean_t[ch], inv_t[ch], gam_t[ch], beta_t[ch]));
        acc_m++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_param_en", 32'(param_en), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_channel_idx", 32'(channel_idx), 0);
  endtask

  task automatic release_chk();
    @(negedge clk); chk("init_ready_c0", 32'(in_ready), 0);
    @(negedge clk); chk("init_ready_c1", 32'(in_ready), 0);
    @(negedge clk); chk("init_ready_c2", 32'(in_ready), 1);
  endtask

  task automatic do_reset(input logic iv);
    @(negedge clk);
    #2;
    in_valid = iv;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1 reset_chk();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    release_chk();
  endtask

  task automatic drain();
    next_cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (expq.size() == 0) break;
    end
    chk("drain_empty", 32'(expq.size()), 0);
  endtask

  task automatic set_rand_params();
    for (int c = 0; c < NCH; c++) begin
      mean_t[c] = 16'($urandom);
      inv_t[c]  = 16'($urandom_range(0, 511));
      gam_t[c]  = 16'($urandom);
      beta_t[c] = 16'($urandom);
    end
  endtask

  typedef struct {
    logic [15:0] x, m, inv, g, b, exp;
  } vec_t;
  vec_t vt[9];

  initial begin
    int found, lat, n, t, ph, grp;
    logic prev_stall, prev_v;
    logic [15:0] prev_d;

    vt[0] = '{16'h0300, 16'h0100, 16'h0080, 16'h0200, 16'h0080, 16'h0280};
    vt[1] = '{16'h7F00, 16'h8100, 16'h0100, 16'h0100, 16'h0000, 16'h7FFF};
    vt[2] = '{16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000};
    vt[3] = '{16'h0200, 16'h0100, 16'h0200, 16'h0180, 16'hFF00, 16'h0200};
    vt[4] = '{16'h0001, 16'h0000, 16'h0080, 16'h0100, 16'h0005, 16'h0005};
    vt[5] = '{16'h4000, 16'h0000, 16'h0100, 16'h0400, 16'h0000, 16'h7FFF};
    vt[6] = '{16'h8000, 16'h7FFF, 16'h0100, 16'hFF00, 16'h0000, 16'h7FFF};
    vt[7] = '{16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0080, 16'h0180};
    vt[8] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0100, 16'h0003, 16'h0002};

    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    set_rand_params();
    #1 rst_n = 1'b0;
    #1 reset_chk();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    release_chk();

    // Directed vectors, one sample at a time through an empty pipeline
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      for (int c = 0; c < NCH; c++) begin
        mean_t[c] = vt[i].m; inv_t[c] = vt[i].inv; gam_t[c] = vt[i].g; beta_t[c] = vt[i].b;
      end
      in_valid = 1'b1;
      in_data = vt[i].x;
      found = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready) begin found = 1; break; end
        next_cycle();
      end
      chk("vec_ready_seen", 32'(found), 1);
      next_cycle();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (out_valid) begin lat = k; break; end
        next_cycle();
      end
      chk("vec_latency", 32'(lat), 3);
      chk("vec_out_data", 32'(out_data), 32'(vt[i].exp));
    end
    drain();

    // Continuous input: 4 accepts, ADV + 2 waits, channel wrap on the second advance
    set_rand_params();
    do_reset(1'b1);
    for (t = 0; t < 21; t++) begin
      if (t > 0) begin
        next_cycle();
        in_data = 16'($urandom);
        @(negedge clk);
      end
      ph = t % 7;
      grp = t / 7;
      chk("tl_in_ready", 32'(in_ready), 32'(ph < 4));
      chk("tl_param_en", 32'(param_en), 32'(ph == 4));
      chk("tl_frame_done", 32'(frame_done), 32'(ph == 4 && (grp % 2) == 1));
      chk("tl_channel_idx", 32'(channel_idx), 32'((grp + ((ph >= 5) ? 1 : 0)) % 2));
    end
    drain();

    // Output stall for 5 cycles mid-stream
    next_cycle();
    set_rand_params();
    prev_stall = 1'b0; prev_v = 1'b0; prev_d = '0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      in_valid = 1'b1;
      in_data = 16'($urandom);
      out_ready = !(c >= 12 && c < 17);
      @(negedge clk);
      if (!out_ready && out_valid) chk("stall_in_ready", 32'(in_ready), 0);
      if (prev_stall && prev_v) begin
        chk("stall_hold_valid", 32'(out_valid), 1);
        chk("stall_hold_data", 32'(out_data), 32'(prev_d));
      end
      prev_stall = !out_ready; prev_v = out_valid; prev_d = out_data;
    end
    drain();

    // Random traffic with random backpressure
    next_cycle();
    set_rand_params();
    for (int c = 0; c < 300; c++) begin
      next_cycle();
      in_valid = ($urandom % 4) != 0;
      in_data = 16'($urandom);
      out_ready = ($urandom % 3) != 0;
    end
    drain();

    // Reset with samples in flight
    set_rand_params();
    do_reset(1'b1);
    next_cycle();
    @(negedge clk);
    n = 0;
    next_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_pre_out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 reset_chk();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    release_chk();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mid_no_stale_out", 32'(n), 0);
    chk("final_sb_empty", 32'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
